// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if
//   Bundles the serial line and the parallel valid/ready output of the
//   framed serial receiver.
//   slave  : the receiver side (consumes si/data_ready, drives results).
//   master : the upstream/consumer side (drives si/data_ready).
//   Signals:
//     si          serial input, idle level 1
//     data_ready  consumer accepts data_out when high with data_valid
//     data_out    last received word
//     data_valid  data_out holds an unconsumed word
//     parity_err  parity status of data_out, qualified by data_valid
//     frame_err   one-cycle pulse on a bad stop bit
//     overrun     one-cycle pulse when a completed word is dropped
//     busy        receiver is inside a frame (not IDLE)
interface serial_frame_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  si;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport slave (
    input  si, data_ready,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
  );

  modport master (
    output si, data_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receives framed serial words (start 0, DATA_WIDTH data bits LSB first,
//   optional parity bit, stop 1) one bit per clock and presents each word
//   on a valid/ready handshake, flagging parity, framing and overrun errors.
//   Ports:
//     clk  system clock, rising-edge sampling
//     rst  asynchronous active-low reset
//     bus  serial_frame_receiver_if.slave (si, data_ready in; data_out,
//          data_valid, parity_err, frame_err, overrun, busy out)
module serial_frame_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_receiver_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  pbit_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  ovr_q;
  logic                  busy_q;

  logic perr_d;
  logic accept_d;

  // Parity check over the assembled word plus the sampled parity bit.
  assign perr_d   = (PARITY_EN != 0) && ((^shift_q ^ pbit_q) != 1'(PARITY_ODD));
  // Output register is free if empty or being consumed on this same edge.
  assign accept_d = !valid_q || bus.data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pbit_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && bus.data_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!bus.si) begin
            state_q <= DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          shift_q[cnt_q] <= bus.si;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          pbit_q  <= bus.si;
          state_q <= STOP;
        end
        STOP: begin
          if (bus.si) begin
            // Good frame: load, or drop the new word if the old one is stuck.
            if (accept_d) begin
              data_q  <= shift_q;
              perr_q  <= perr_d;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A low line here is the tail of a broken frame, not a start bit.
          if (bus.si) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Scenario tasks drive serial frames and check status inline; a monitor
//   process pops expected words from a scoreboard queue whenever a new word
//   is presented on data_out/data_valid.
module tb_serial_frame_receiver;

  localparam int DW    = 8;
  localparam int P_EN  = 1;
  localparam int P_ODD = 0;
  localparam int FRAME_LEN = DW + 2 + P_EN;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  logic [8:0]  exp_q[$];   // {parity_err, data}
  logic [12:0] obs;        // {data_valid, data_out, parity_err, frame_err, overrun, busy}

  serial_frame_receiver_if #(.DATA_WIDTH(DW)) bus ();

  serial_frame_receiver #(
    .DATA_WIDTH(DW),
    .PARITY_EN (P_EN),
    .PARITY_ODD(P_ODD)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  assign obs = {bus.data_valid, bus.data_out, bus.parity_err, bus.frame_err,
                bus.overrun, bus.busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a new word appears when data_valid is seen high
  // after being low, or after an edge that performed a handshake.
  initial begin
    logic prev_dv;
    logic prev_hs;
    logic [8:0] exp_w;
    prev_dv = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.data_valid && (!prev_dv || prev_hs)) begin
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL sb_unexpected: got word %h pe=%b, required none", bus.data_out, bus.parity_err);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.parity_err, bus.data_out} !== exp_w) begin
            miscompares = miscompares + 1;
            $display("FAIL sb_word: got pe/data %h, required %h", {bus.parity_err, bus.data_out}, exp_w);
          end
        end
      end
      prev_dv = rst_n & bus.data_valid;
      prev_hs = rst_n & bus.data_valid & bus.data_ready;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.si = b;
    @(posedge clk);
    #1;
  endtask

  // Start bit, data bits LSB first, then parity bit if enabled (no stop bit).
  task automatic send_body(input logic [7:0] d, input logic pb);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (P_EN != 0) send_bit(pb);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.si = 1'b1;
    bus.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (obs !== 13'h0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_outputs: got %h, required %h", obs, 13'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== 13'h0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_idle: got %h, required %h", obs, 13'h0);
    end
  endtask

  task automatic test_good_frame;
    bus.data_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    send_body(8'hA5, 1'b0);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares = miscompares + 1;
      $display("FAIL good_before_stop: got %h, required %h", obs, {1'b0, 8'h00, 4'b0001});
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL good_stop: got %h, required %h", obs, {1'b1, 8'hA5, 4'b0000});
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL good_one_cycle: got %h, required %h", obs, {1'b0, 8'hA5, 4'b0000});
    end
  endtask

  task automatic test_parity_err;
    exp_q.push_back({1'b1, 8'hA5});
    send_body(8'hA5, 1'b1);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL parity_stop: got %h, required %h", obs, {1'b1, 8'hA5, 4'b1000});
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL parity_hold: got %h, required %h", obs, {1'b0, 8'hA5, 4'b1000});
    end
  endtask

  task automatic test_framing;
    send_body(8'h3C, 1'b0);
    send_bit(1'b0);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      miscompares = miscompares + 1;
      $display("FAIL frame_stop: got %h, required %h", obs, {1'b0, 8'hA5, 4'b1101});
    end
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      vectors = vectors + 1;
      if (obs !== {1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1}) begin
        miscompares = miscompares + 1;
        $display("FAIL frame_wait%0d: got %h, required %h", i, obs, {1'b0, 8'hA5, 4'b1001});
      end
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL frame_recover: got %h, required %h", obs, {1'b0, 8'hA5, 4'b1000});
    end
    exp_q.push_back({1'b0, 8'h11});
    send_body(8'h11, 1'b0);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL frame_next_word: got %h, required %h", obs, {1'b1, 8'h11, 4'b0000});
    end
    send_bit(1'b1);
  endtask

  task automatic test_overrun;
    bus.data_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h3C});
    send_body(8'h3C, 1'b0);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL ovr_first: got %h, required %h", obs, {1'b1, 8'h3C, 4'b0000});
    end
    send_body(8'h81, 1'b0);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL ovr_pulse: got %h, required %h", obs, {1'b1, 8'h3C, 4'b0010});
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL ovr_single: got %h, required %h", obs, {1'b1, 8'h3C, 4'b0000});
    end
    bus.data_ready = 1'b1;
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL ovr_drain: got %h, required %h", obs, {1'b0, 8'h3C, 4'b0000});
    end
  endtask

  task automatic test_async_reset;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);  // low nibble of 0xF0
    vectors = vectors + 1;
    if (bus.busy !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL arst_busy_before: got %b, required 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    bus.si = 1'b1;
    #1;
    vectors = vectors + 1;
    if (obs !== 13'h0) begin
      miscompares = miscompares + 1;
      $display("FAIL arst_immediate: got %h, required %h", obs, 13'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    exp_q.push_back({1'b0, 8'h5A});
    send_body(8'h5A, 1'b0);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL arst_after: got %h, required %h", obs, {1'b1, 8'h5A, 4'b0000});
    end
    send_bit(1'b1);
  endtask

  task automatic test_back_to_back;
    int t0;
    bus.data_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_body(8'h00, 1'b0);
    send_bit(1'b1);
    t0 = cyc;
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_first: got %h, required %h", obs, {1'b1, 8'h00, 4'b0000});
    end
    send_body(8'hFF, 1'b0);
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_second: got %h, required %h", obs, {1'b1, 8'hFF, 4'b0000});
    end
    vectors = vectors + 1;
    if (cyc - t0 !== FRAME_LEN) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - t0, FRAME_LEN);
    end
    send_bit(1'b1);
    vectors = vectors + 1;
    if (obs !== {1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_drain: got %h, required %h", obs, {1'b0, 8'hFF, 4'b0000});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.si = 1'b1;
    bus.data_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_framing();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    repeat (2) send_bit(1'b1);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL sb_leftover: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
